// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, reset PC, buffer depth and fetch FSM encodings
package if_fetch_unit_pkg;

    localparam int DEF_PC_WIDTH    = 32;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_RESET_PC    = 0;
    localparam int BUF_DEPTH       = 2;
    localparam int CNT_WIDTH       = $clog2(BUF_DEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buf.sv
// rtl/if_fetch_unit_fetch_buf.sv - 2-entry in-order {pc, inst} FIFO with registered head
module fetch_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [CNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]     head
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;

    assign head = ent0;

    // Caller guarantees pop only when non-empty and push only when a slot frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) ent0 <= din;
                    else             ent1 <= din;
                    count <= count + 1'b1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 1'b1;
                end
                2'b11: begin
                    if (count == CNT_WIDTH'(BUF_DEPTH)) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end; optional IF_ALIGN_CHECK_EN adds misalign_o
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   work_ena,
    input  logic                   pc_jump,
    input  logic [PC_WIDTH-1:0]    pc_target,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [INSTR_WIDTH-1:0] inst_o
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic                   misalign_o
`endif
);

    fetch_state_t          state;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   tag;
    logic                  inflight;
    logic                  discard;
    logic [CNT_WIDTH-1:0]  count;
    logic [PC_WIDTH-1:0]   jump_pc;
    logic                  run;
    logic                  jump;
    logic                  flush;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [2:0]            limit;

    assign run   = (state == S_RUN) && work_ena;
    assign jump  = run && pc_jump;
    assign flush = ((state == S_RUN) && !work_ena) || jump;

    // A redirect voids any pop and push in its own cycle.
    assign pop   = valid_o && ready_i && !jump;
    assign push  = inflight && !discard && run && !pc_jump;

    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign limit     = 3'(BUF_DEPTH) + {2'b00, pop};
    assign issue     = run && !pc_jump && (occupancy < limit);

    assign imem_en   = issue;
    assign imem_addr = fetch_pc;
    assign valid_o   = (count != '0);

`ifdef IF_ALIGN_CHECK_EN
    assign jump_pc = pc_target - (pc_target % PC_WIDTH'(PC_STEP));
`else
    assign jump_pc = pc_target;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            discard  <= flush && inflight;
            if (issue) tag <= fetch_pc;
`ifdef IF_ALIGN_CHECK_EN
            misalign_o <= jump && ((pc_target % PC_WIDTH'(PC_STEP)) != '0);
`endif
            case (state)
                S_IDLE: begin
                    fetch_pc <= RESET_PC;
                    if (work_ena) state <= S_RUN;
                end
                S_RUN: begin
                    if (!work_ena) begin
                        state    <= S_IDLE;
                        fetch_pc <= RESET_PC;
                    end else if (pc_jump) begin
                        fetch_pc <= jump_pc;
                    end else if (issue) begin
                        fetch_pc <= fetch_pc + PC_WIDTH'(PC_STEP);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fetch_buf #(
        .WIDTH(PC_WIDTH + INSTR_WIDTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clear(flush),
        .push (push),
        .din  ({tag, imem_rdata}),
        .pop  (pop),
        .count(count),
        .head ({pc_o, inst_o})
    );

endmodule
